// File: rtl/seg_scan_pkg.sv
// Shared constants and pattern decoder for the seven-segment scan receiver.
// Segment bit order is gfedcba: bit0 = a ... bit6 = g, 1 = lit.
package seg_scan_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_HA = 7'h77;
    localparam logic [6:0] SEG_HB = 7'h7C;
    localparam logic [6:0] SEG_HC = 7'h39;
    localparam logic [6:0] SEG_HD = 7'h5E;
    localparam logic [6:0] SEG_HE = 7'h79;
    localparam logic [6:0] SEG_HF = 7'h71;

    typedef struct packed {
        logic       legal;
        logic       blank;
        logic [3:0] nibble;
    } seg_dec_t;

    // Map a segment pattern to its hex nibble; blank and unknown patterns are flagged.
    function automatic seg_dec_t seg_decode(input logic [6:0] pat);
        seg_dec_t r;
        r.legal  = 1'b1;
        r.blank  = 1'b0;
        r.nibble = 4'h0;
        case (pat)
            SEG_0:  r.nibble = 4'h0;
            SEG_1:  r.nibble = 4'h1;
            SEG_2:  r.nibble = 4'h2;
            SEG_3:  r.nibble = 4'h3;
            SEG_4:  r.nibble = 4'h4;
            SEG_5:  r.nibble = 4'h5;
            SEG_6:  r.nibble = 4'h6;
            SEG_7:  r.nibble = 4'h7;
            SEG_8:  r.nibble = 4'h8;
            SEG_9:  r.nibble = 4'h9;
            SEG_HA: r.nibble = 4'hA;
            SEG_HB: r.nibble = 4'hB;
            SEG_HC: r.nibble = 4'hC;
            SEG_HD: r.nibble = 4'hD;
            SEG_HE: r.nibble = 4'hE;
            SEG_HF: r.nibble = 4'hF;
            SEG_BLANK: begin
                r.legal = 1'b0;
                r.blank = 1'b1;
            end
            default: r.legal = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational segment-pattern to nibble decoder with legal/blank flags.
module seg_hex_decode
    import seg_scan_pkg::*;
(
    input  logic [6:0] seven_seg,
    output logic [3:0] nibble,
    output logic       legal,
    output logic       blank
);

    seg_dec_t dec;

    // Table lookup of the sampled pattern.
    always_comb begin
        dec    = seg_decode(seven_seg);
        nibble = dec.nibble;
        legal  = dec.legal;
        blank  = dec.blank;
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Seven-segment scan receiver: samples the multiplexed segment bus and
// one-hot digit select, waits for a stable window, then recovers per-digit
// nibbles, validity, frame completion and illegal-pattern pulses.
// Optional feature macro SEG_SCAN_ERR_CNT_EN adds an 8-bit saturating
// err_count output counting decode_err pulses.
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seven_seg,
    input  logic [NUM_DIGITS-1:0]   dig,
    output logic [4*NUM_DIGITS-1:0] digit_val,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_done,
`ifdef SEG_SCAN_ERR_CNT_EN
    output logic [7:0]              err_count,
`endif
    output logic                    decode_err
);

    localparam int CNT_W = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(STABLE_CYCLES);

    // Stage p0: registered sample pair S and its stability count
    logic [6:0]            seg_p0;
    logic [NUM_DIGITS-1:0] dig_p0;
    logic [CNT_W-1:0]      cnt_p0;
    logic [NUM_DIGITS-1:0] seen;

    logic [3:0] dec_nibble;
    logic       dec_legal;
    logic       dec_blank;
    logic       vld_p0;

    seg_hex_decode u_dec (
        .seven_seg (seg_p0),
        .nibble    (dec_nibble),
        .legal     (dec_legal),
        .blank     (dec_blank)
    );

    // Capture fires only on the single cycle the count equals the threshold.
    assign vld_p0 = (cnt_p0 == CNT_HIT);

    // Register the inputs and count how long the sample pair has been stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_p0 <= '0;
            dig_p0 <= '0;
            cnt_p0 <= '0;
        end else begin
            seg_p0 <= seven_seg;
            dig_p0 <= dig;
            if (!$onehot(dig) || (seven_seg != seg_p0) || (dig != dig_p0))
                cnt_p0 <= CNT_W'(1);
            else if (cnt_p0 != CNT_MAX)
                cnt_p0 <= cnt_p0 + CNT_W'(1);
        end
    end

    // Stage p1: apply the capture to the selected digit and track the frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_val   <= '0;
            digit_valid <= '0;
            decode_err  <= 1'b0;
        end else begin
            decode_err <= vld_p0 && !dec_legal && !dec_blank;
            if (vld_p0) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (dig_p0[i]) begin
                        digit_valid[i] <= dec_legal;
                        if (dec_legal)
                            digit_val[4*i +: 4] <= dec_nibble;
                    end
                end
            end
        end
    end

    // A full seen mask raises frame_done and clears; a capture on that edge is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen       <= '0;
            frame_done <= 1'b0;
        end else if (&seen) begin
            seen       <= '0;
            frame_done <= 1'b1;
        end else begin
            frame_done <= 1'b0;
            if (vld_p0 && (dec_legal || dec_blank))
                seen <= seen | dig_p0;
        end
    end

`ifdef SEG_SCAN_ERR_CNT_EN
    // Saturating count of illegal-pattern captures, updated with the pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_count <= '0;
        else if (vld_p0 && !dec_legal && !dec_blank && (err_count != 8'hFF))
            err_count <= err_count + 8'd1;
    end
`endif

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side counterpart of the multiplexed seven-segment display driver. It samples the time-multiplexed segment bus and one-hot digit-select lines and recovers the hex nibble shown on each digit. It also reports per-digit validity, scan-frame completion and illegal patterns. It sits on the verification/loopback side of the digital-lock top level, observing the display outputs so that the lock state can be read back on-chip.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits; width of `dig`.
- STABLE_CYCLES, 4, consecutive identical samples (≥2) required before a capture.
- `clk` in 1: single clock, all logic on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `seven_seg` in 7: segment pattern; bit0=a … bit6=g; a 1 means the segment is lit.
- `dig` in NUM_DIGITS: digit select, active-high; legal only when exactly one bit is set.
- `digit_val` out 4*NUM_DIGITS: recovered nibbles; digit i occupies [4i+3:4i].
- `digit_valid` out NUM_DIGITS: 1 means digit i holds a legally decoded value.
- `frame_done` out 1: one-cycle pulse when every digit has been captured since the last pulse.
- `decode_err` out 1: one-cycle pulse on a stable, selected, unrecognised pattern.

## Operation
- **Input stage.** `seven_seg` and `dig` are registered on every edge, forming the sample pair S.
- **Stability counter** (saturating, width clog2(STABLE_CYCLES)+1):
  - Set to 1 when S differs from the previous S or when `dig` is not one-hot.
  - Otherwise incremented.
  - A capture fires on the single edge where the counter reaches STABLE_CYCLES. A window held longer does not capture again until S changes.
  - A non-one-hot `dig` (zero or multi-hot) never captures and holds the counter at 1.
- **Decode table** (gfedcba hex → nibble): 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→B, 39→C, 5E→D, 79→E, 71→F. Any other pattern except 00 is illegal.
- **Capture for selected digit i:**
  - Legal pattern: `digit_val[i]` is loaded, `digit_valid[i]` is set to 1, and seen-mask bit i is set.
  - Pattern 00 (blank): `digit_val[i]` is unchanged, `digit_valid[i]` is set to 0, and seen-mask bit i is set.
  - Illegal pattern: `digit_val[i]` is unchanged, `digit_valid[i]` is set to 0, `decode_err` pulses, and the seen mask is not updated.
- **Frame tracking.** When the seen mask becomes all ones, `frame_done` pulses on the next edge and the mask clears in the same edge. A digit captured twice before the frame completes only refreshes its value.
- **Reset** (at any time, including mid-window) sets every output and all internal state to 0: `digit_val`=0, `digit_valid`=0, `frame_done`=0, `decode_err`=0, counter=0, seen mask=0, S=0.

## Timing
- Input appears before edge k and is registered at edge k.
- The capture updates `digit_val` / `digit_valid` at edge k+STABLE_CYCLES.
- `decode_err` pulses in the same cycle as the capture.
- `frame_done` is asserted one edge after the final capture that completes the mask; it is high for exactly one cycle.
- Any change of S before the count reaches STABLE_CYCLES discards the window, so a glitch shorter than STABLE_CYCLES samples is invisible.
- Simultaneous capture of the last missing digit and mask clear: the mask clears, and the captured bit is not carried into the next frame.
- No backpressure; outputs are level registers that the reader samples freely.

## Configuration
- `SEG_SCAN_ERR_CNT_EN`:
  - Defined: adds output `err_count` (8 bits), which increments on each `decode_err` pulse, saturates at 255 and resets to 0.
  - Undefined: the port and counter are absent, and all other behaviour is identical.

## Structure
- **Package `seg_scan_pkg`:**
  - The 16 segment-pattern constants plus SEG_BLANK.
  - The segment-bit index constants.
  - A function mapping 7-bit pattern → {legal, blank, nibble}.
- **Sub-module `seg_hex_decode`:** purely combinational pattern→nibble/legal/blank decoder, instantiated once.
- **Top:** input registers, stability counter, capture/seen-mask logic and the optional error counter.

## Test plan
- **Reset values.** Assert `rst` asynchronously mid-cycle → all outputs 0 immediately. Release, hold inputs at 0 for 20 cycles → outputs remain 0.
- **Single capture.** `dig`=0010, `seven_seg`=4F held 6 cycles → `digit_val`[7:4]=3 and `digit_valid`=0010 at edge 1+STABLE_CYCLES. Exactly one capture occurs.
- **Full frame.** Scan digits 0..3 showing 06, 5B, 4F, 66, each held 5 cycles:
  - `digit_val`=16'h4321 and `digit_valid`=1111.
  - `frame_done` is a single pulse.
  - A repeated scan produces a second pulse.
- **Glitch and illegal input:**
  - `dig`=0001 with `seven_seg`=3F held 3 cycles then changed → no capture.
  - Pattern 01 held 4 cycles → `decode_err` pulse, `digit_valid`[0]=0, value retained.
- **Illegal select.** `dig`=0011 or 0000 with 3F held 10 cycles → no capture and no error.
- **Reset mid-window.** Pulse `rst` at sample 3 of a valid window → no capture. With `SEG_SCAN_ERR_CNT_EN`, 300 illegal captures → `err_count`=255.
